// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the DMEM arbiter
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2,
        ACK   = 2'd3
    } arb_state_e;

    localparam logic WORR_WRITE = 1'b1;
    localparam logic WORR_READ  = 1'b0;

endpackage

// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and DMEM signal bundle around the arbiter
interface dmem_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              cpu_ena;
    logic              cpu_worr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_worr;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic              dm_ena;
    logic              dm_worr;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;

    logic [CNT_W-1:0]  force_cnt;

    modport slave (
        input  cpu_ena, cpu_worr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_worr, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output dm_ena, dm_worr, dm_addr, dm_wdata,
        input  dm_rdata,
        output force_cnt
    );

    modport master (
        output cpu_ena, cpu_worr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_worr, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  dm_ena, dm_worr, dm_addr, dm_wdata,
        output dm_rdata,
        input  force_cnt
    );

endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares single-port DMEM between CPU and debug requester
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 16
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    arb_state_e        r_state;
    arb_state_e        w_next;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_pend_worr;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_wdata;
    logic              r_dbg_ack;
    logic [DATA_W-1:0] r_dbg_rdata;
    logic [CNT_W-1:0]  r_force_cnt;
    logic              w_dbg_own;
    logic              w_pend_read;

    assign w_pend_read = (r_pend_worr == WORR_READ);

    // Debug owns DMEM only in its service cycle: an idle PEND cycle or FORCE.
    always_comb begin
        w_next    = r_state;
        w_dbg_own = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.dbg_req) w_next = PEND;
            end
            PEND: begin
                if (!bus.cpu_ena) begin
                    w_dbg_own = 1'b1;
                    w_next    = ACK;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_next = FORCE;
                end
            end
            FORCE: begin
                w_dbg_own = 1'b1;
                w_next    = ACK;
            end
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wait_cnt   <= '0;
            r_pend_worr  <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_wdata <= '0;
            r_dbg_ack    <= 1'b0;
            r_dbg_rdata  <= '0;
            r_force_cnt  <= '0;
        end else begin
            r_state   <= w_next;
            r_dbg_ack <= (w_next == ACK);
            if (r_state == IDLE && bus.dbg_req) begin
                r_pend_worr  <= bus.dbg_worr;
                r_pend_addr  <= bus.dbg_addr;
                r_pend_wdata <= bus.dbg_wdata;
                r_wait_cnt   <= '0;
            end else if (r_state == PEND && bus.cpu_ena && r_wait_cnt != WAIT_LAST) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_dbg_own && w_pend_read) r_dbg_rdata <= bus.dm_rdata;
            if (r_state == FORCE && r_force_cnt != '1) r_force_cnt <= r_force_cnt + CNT_W'(1);
        end
    end

    assign bus.dm_ena    = w_dbg_own | bus.cpu_ena;
    assign bus.dm_worr   = w_dbg_own ? r_pend_worr  : bus.cpu_worr;
    assign bus.dm_addr   = w_dbg_own ? r_pend_addr  : bus.cpu_addr;
    assign bus.dm_wdata  = w_dbg_own ? r_pend_wdata : bus.cpu_wdata;
    assign bus.cpu_rdata = w_dbg_own ? '0 : bus.dm_rdata;
    assign bus.cpu_stall = (r_state == FORCE);
    assign bus.dbg_ack   = r_dbg_ack;
    assign bus.dbg_rdata = r_dbg_rdata;
    assign bus.force_cnt = r_force_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    // Narrow force counter so saturation is reachable in a short run.
    localparam int TB_CNT_W = 4;
    localparam logic [TB_CNT_W-1:0] CNT_MAX = 4'hF;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    logic [31:0] mem [32] = '{7: 32'h0707_0707, default: 32'h0};

    dmem_arbiter_if #(.ADDR_W(5), .DATA_W(32), .CNT_W(TB_CNT_W)) bus ();

    dmem_arbiter #(
        .ADDR_W(5), .DATA_W(32), .MAX_WAIT(4), .CNT_W(TB_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.dm_rdata = mem[bus.dm_addr];

    always @(posedge clk) begin
        if (bus.dm_ena && bus.dm_worr) mem[bus.dm_addr] <= bus.dm_wdata;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.cpu_ena = 1'b0; bus.cpu_worr = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dbg_req = 1'b0; bus.dbg_worr = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;
        tick; tick;
        n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", bus.cpu_stall); end
        n_vec++; if (bus.dbg_ack !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b want 0", bus.dbg_ack); end
        n_vec++; if (bus.force_cnt !== 4'h0) begin n_err++; $display("FAIL reset_force_cnt: got %h want 0", bus.force_cnt); end
        n_vec++; if (bus.dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_dbg_rdata: got %h want 0", bus.dbg_rdata); end
        rst = 1'b0;
        bus.cpu_ena = 1'b1; bus.cpu_worr = WORR_WRITE; bus.cpu_addr = 5'd3; bus.cpu_wdata = 32'h1234;
        #1;
        n_vec++; if (bus.dm_ena !== 1'b1 || bus.dm_worr !== 1'b1 || bus.dm_addr !== 5'd3 || bus.dm_wdata !== 32'h1234) begin
            n_err++; $display("FAIL cpu_passthru: got ena=%b worr=%b addr=%0d wdata=%h want 1 1 3 00001234", bus.dm_ena, bus.dm_worr, bus.dm_addr, bus.dm_wdata);
        end
        n_vec++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL cpu_write_stall: got %b want 0", bus.cpu_stall); end
        tick;
        bus.cpu_ena = 1'b0;
        n_vec++; if (mem[3] !== 32'h1234) begin n_err++; $display("FAIL cpu_write_mem3: got %h want 00001234", mem[3]); end
        n_vec++; if (bus.dbg_ack !== 1'b0) begin n_err++; $display("FAIL cpu_write_ack: got %b want 0", bus.dbg_ack); end
    endtask

    task automatic test_dbg_write_read;
        bus.cpu_ena = 1'b0;
        bus.dbg_req = 1'b1; bus.dbg_worr = WORR_WRITE; bus.dbg_addr = 5'd5; bus.dbg_wdata = 32'hDEAD_BEEF;
        #1;
        n_vec++; if (bus.dm_ena !== 1'b0) begin n_err++; $display("FAIL dbgw_capture_dm_ena: got %b want 0", bus.dm_ena); end
        tick;
        n_vec++; if (bus.dm_ena !== 1'b1 || bus.dm_worr !== 1'b1 || bus.dm_addr !== 5'd5 || bus.dm_wdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL dbgw_service: got ena=%b worr=%b addr=%0d wdata=%h want 1 1 5 deadbeef", bus.dm_ena, bus.dm_worr, bus.dm_addr, bus.dm_wdata);
        end
        n_vec++; if (bus.dbg_ack !== 1'b0) begin n_err++; $display("FAIL dbgw_early_ack: got %b want 0", bus.dbg_ack); end
        tick;
        n_vec++; if (bus.dbg_ack !== 1'b1) begin n_err++; $display("FAIL dbgw_ack: got %b want 1", bus.dbg_ack); end
        n_vec++; if (mem[5] !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dbgw_mem5: got %h want deadbeef", mem[5]); end
        bus.dbg_req = 1'b0;
        tick;
        n_vec++; if (bus.dbg_ack !== 1'b0) begin n_err++; $display("FAIL dbgw_ack_pulse: got %b want 0", bus.dbg_ack); end
        bus.dbg_req = 1'b1; bus.dbg_worr = WORR_READ; bus.dbg_addr = 5'd5; bus.dbg_wdata = '0;
        tick;
        n_vec++; if (bus.dm_ena !== 1'b1 || bus.dm_worr !== 1'b0 || bus.dm_addr !== 5'd5) begin
            n_err++; $display("FAIL dbgr_service: got ena=%b worr=%b addr=%0d want 1 0 5", bus.dm_ena, bus.dm_worr, bus.dm_addr);
        end
        tick;
        n_vec++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL dbgr_ack_data: got ack=%b rdata=%h want 1 deadbeef", bus.dbg_ack, bus.dbg_rdata);
        end
        bus.dbg_req = 1'b0;
        tick;
        n_vec++; if (bus.dbg_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL dbgr_hold: got %h want deadbeef", bus.dbg_rdata); end
    endtask

    task automatic test_force;
        bus.cpu_ena = 1'b1; bus.cpu_worr = WORR_WRITE; bus.cpu_addr = 5'd12; bus.cpu_wdata = 32'h1;
        bus.dbg_req = 1'b1; bus.dbg_worr = WORR_READ; bus.dbg_addr = 5'd7;
        tick;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (bus.cpu_stall !== 1'b0 || bus.dm_addr !== 5'd12 || bus.dbg_ack !== 1'b0) begin
                n_err++; $display("FAIL force_pend%0d: got stall=%b addr=%0d ack=%b want 0 12 0", i, bus.cpu_stall, bus.dm_addr, bus.dbg_ack);
            end
            tick;
        end
        bus.cpu_addr = 5'd13; bus.cpu_wdata = 32'h5555;
        #1;
        n_vec++; if (bus.cpu_stall !== 1'b1 || bus.dm_addr !== 5'd7 || bus.dm_ena !== 1'b1 || bus.dm_worr !== 1'b0) begin
            n_err++; $display("FAIL force_cycle: got stall=%b addr=%0d ena=%b worr=%b want 1 7 1 0", bus.cpu_stall, bus.dm_addr, bus.dm_ena, bus.dm_worr);
        end
        n_vec++; if (bus.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL force_cpu_rdata: got %h want 0", bus.cpu_rdata); end
        tick;
        bus.cpu_ena = 1'b0;
        n_vec++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 32'h0707_0707 || bus.cpu_stall !== 1'b0) begin
            n_err++; $display("FAIL force_ack: got ack=%b rdata=%h stall=%b want 1 07070707 0", bus.dbg_ack, bus.dbg_rdata, bus.cpu_stall);
        end
        n_vec++; if (bus.force_cnt !== 4'd1) begin n_err++; $display("FAIL force_cnt1: got %0d want 1", bus.force_cnt); end
        n_vec++; if (mem[13] !== 32'h0) begin n_err++; $display("FAIL force_cpu_blocked: got %h want 0", mem[13]); end
        bus.dbg_req = 1'b0;
        tick;
    endtask

    task automatic test_busy_then_idle;
        bus.cpu_ena = 1'b1; bus.cpu_worr = WORR_READ; bus.cpu_addr = 5'd0;
        bus.dbg_req = 1'b1; bus.dbg_worr = WORR_READ; bus.dbg_addr = 5'd3;
        tick;
        n_vec++; if (bus.cpu_stall !== 1'b0 || bus.dm_addr !== 5'd0) begin
            n_err++; $display("FAIL busy_pend: got stall=%b addr=%0d want 0 0", bus.cpu_stall, bus.dm_addr);
        end
        tick;
        bus.cpu_ena = 1'b0;
        #1;
        n_vec++; if (bus.dm_ena !== 1'b1 || bus.dm_addr !== 5'd3 || bus.cpu_stall !== 1'b0) begin
            n_err++; $display("FAIL busy_idle_service: got ena=%b addr=%0d stall=%b want 1 3 0", bus.dm_ena, bus.dm_addr, bus.cpu_stall);
        end
        tick;
        n_vec++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 32'h1234 || bus.force_cnt !== 4'd1) begin
            n_err++; $display("FAIL busy_ack: got ack=%b rdata=%h cnt=%0d want 1 00001234 1", bus.dbg_ack, bus.dbg_rdata, bus.force_cnt);
        end
        bus.dbg_req = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_pend;
        bus.cpu_ena = 1'b1; bus.cpu_worr = WORR_READ; bus.cpu_addr = 5'd0;
        bus.dbg_req = 1'b1; bus.dbg_worr = WORR_WRITE; bus.dbg_addr = 5'd9; bus.dbg_wdata = 32'hAA;
        tick; tick;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.cpu_stall !== 1'b0 || bus.dbg_ack !== 1'b0 || bus.force_cnt !== 4'd0 || bus.dm_addr !== 5'd0) begin
            n_err++; $display("FAIL midrst_async: got stall=%b ack=%b cnt=%0d addr=%0d want 0 0 0 0", bus.cpu_stall, bus.dbg_ack, bus.force_cnt, bus.dm_addr);
        end
        bus.dbg_req = 1'b0; bus.cpu_ena = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick; tick;
        n_vec++; if (bus.dbg_ack !== 1'b0 || mem[9] !== 32'h0) begin
            n_err++; $display("FAIL midrst_abandon: got ack=%b mem9=%h want 0 0", bus.dbg_ack, mem[9]);
        end
        n_vec++; if (bus.dm_ena !== 1'b0 || bus.dbg_rdata !== 32'h0) begin
            n_err++; $display("FAIL midrst_idle: got dm_ena=%b rdata=%h want 0 0", bus.dm_ena, bus.dbg_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        logic [TB_CNT_W-1:0] exp_cnt;
        bus.cpu_ena = 1'b1; bus.cpu_worr = WORR_READ; bus.cpu_addr = 5'd0;
        bus.dbg_req = 1'b1; bus.dbg_worr = WORR_READ; bus.dbg_addr = 5'd3;
        for (int ev = 0; ev < 17; ev++) begin
            cycles = 0;
            do begin
                tick;
                cycles++;
            end while (bus.dbg_ack !== 1'b1 && cycles < 20);
            exp_cnt = (ev + 1 >= 15) ? CNT_MAX : TB_CNT_W'(ev + 1);
            n_vec++; if (cycles !== ((ev == 0) ? 6 : 7)) begin
                n_err++; $display("FAIL b2b_latency%0d: got %0d cycles want %0d", ev, cycles, (ev == 0) ? 6 : 7);
            end
            n_vec++; if (bus.force_cnt !== exp_cnt) begin
                n_err++; $display("FAIL b2b_force_cnt%0d: got %h want %h", ev, bus.force_cnt, exp_cnt);
            end
        end
        bus.dbg_req = 1'b0; bus.cpu_ena = 1'b0;
        tick;
        n_vec++; if (bus.dbg_ack !== 1'b0 || bus.dm_ena !== 1'b0 || bus.force_cnt !== CNT_MAX) begin
            n_err++; $display("FAIL b2b_end: got ack=%b dm_ena=%b cnt=%h want 0 0 f", bus.dbg_ack, bus.dm_ena, bus.force_cnt);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_dbg_write_read;
        test_force;
        test_busy_then_idle;
        test_reset_mid_pend;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the CPU load/store path and a debug/loader requester; sits between CPU, DMEM and the debug port in the top level.
- CPU owns DMEM by default, so its single-cycle accesses are unaffected.
- Debug accesses use idle CPU cycles. If the CPU keeps DMEM busy for MAX_WAIT cycles, the arbiter stalls the CPU for one cycle and services the debug access.

Parameters:
ADDR_W, 5, DMEM word address width
DATA_W, 32, data width
MAX_WAIT, 4, cycles a pending debug access waits before forcing a CPU stall; legal range is MAX_WAIT >= 1
CNT_W, 16, width of the force-event counter

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  asynchronous, active-high reset
cpu_ena  in  1  CPU requests a DMEM access this cycle
cpu_worr  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  read data to the CPU
cpu_stall  out  1  CPU must hold its PC and architectural state this cycle
dbg_req  in  1  debug request, level-sensitive
dbg_worr  in  1  1=write, 0=read
dbg_addr  in  ADDR_W  debug address
dbg_wdata  in  DATA_W  debug write data
dbg_ack  out  1  one-cycle completion pulse
dbg_rdata  out  DATA_W  registered read data, valid while dbg_ack=1 and held until the next ack
dm_ena  out  1  DMEM enable
dm_worr  out  1  DMEM write/read select
dm_addr  out  ADDR_W  DMEM address
dm_wdata  out  DATA_W  DMEM write data
dm_rdata  in  DATA_W  DMEM combinational read data
force_cnt  out  CNT_W  saturating count of FORCE entries

Behaviour:
- FSM states: IDLE, PEND, FORCE, ACK.
- Registered state: state, wait_cnt, pending worr/addr/wdata, dbg_ack, dbg_rdata, force_cnt.
- Reset: state=IDLE, wait_cnt=0, pending regs=0, dbg_ack=0, dbg_rdata=0, force_cnt=0, hence cpu_stall=0. Reset during any state abandons the pending access with no ack and no DMEM write.
- IDLE:
  - DMEM is driven from the cpu_* inputs.
  - If dbg_req=1: capture dbg_worr/addr/wdata into the pending regs, clear wait_cnt, go to PEND.
  - The debug access is never serviced in the same cycle it is captured, which gives a minimum latency of 2 cycles from req to ack.
- PEND, with cpu_ena=0:
  - DMEM is driven from the pending regs with dm_ena=1.
  - At the edge: if the pending access is a read, latch dm_rdata into dbg_rdata; go to ACK.
- PEND, with cpu_ena=1:
  - DMEM is driven by the CPU.
  - If wait_cnt==MAX_WAIT-1, go to FORCE; otherwise wait_cnt+1.
- FORCE:
  - cpu_stall=1 (combinational from state); DMEM is driven from the pending regs; cpu_rdata=0.
  - At the edge: latch read data as in PEND; force_cnt+1, saturating at all-ones; go to ACK.
- ACK:
  - dbg_ack=1 (registered output of the state); DMEM is driven by the CPU.
  - dbg_req is ignored in this cycle; always go to IDLE.
- Handshake rules:
  - The requester holds dbg_req and its operands stable until it sees dbg_ack.
  - It must drop dbg_req by the edge that ends the ACK cycle. dbg_req still high in IDLE is a new request.
  - Operand changes after capture are ignored.
- cpu_rdata = dm_rdata whenever the CPU owns DMEM, including cycles with cpu_ena=0.
- In DMEM-owner cycles with cpu_ena=0 and no debug service, dm_ena=0 and the remaining dm_* outputs pass through the cpu_* inputs.
- Debug write data lands in DMEM at the service-cycle edge, so a debug read of the same address issued afterwards sees it.
- Worst-case debug latency: 1 capture cycle + MAX_WAIT wait cycles + 1 service cycle, then ack.
- cpu_stall is asserted for exactly one cycle per FORCE and never in any other state.

Decomposition:
- Shared package dmem_arb_pkg holds:
  - the state enum (IDLE/PEND/FORCE/ACK, 2-bit encoding);
  - constants WORR_WRITE=1'b1 and WORR_READ=1'b0.
- No sub-module: the saturating counter and the output mux stay inline. The CPU top-level instantiates this block between the CPU and DMEM, and the CPU gains a stall input.

Test Plan:
- Reset is asserted, then released with dbg_req=0 and a CPU write of 0x1234 to address 3 → dm_* mirror the CPU, cpu_stall=0, dbg_ack=0, force_cnt=0, and DMEM[3]=0x1234.
- CPU idle; dbg write of 0xDEADBEEF to address 5 → service in the 2nd cycle, dbg_ack pulses in the 3rd. A subsequent dbg read of address 5 returns dbg_rdata=0xDEADBEEF with its ack.
- CPU accessing every cycle, MAX_WAIT=4; dbg read of address 7 → 4 PEND cycles, then 1 cycle with cpu_stall=1 and dm_addr=7, then ack. Check force_cnt=1 and that the CPU access in the stalled cycle is not performed.
- CPU busy for 2 cycles, then idle; dbg read → serviced in the first idle cycle, no stall, force_cnt unchanged.
- Reset asserted mid-PEND with a pending dbg write of 0xAA to address 9 → no ack, DMEM[9] unchanged, and the FSM is in IDLE after release.
- dbg_req held high through ACK, with force_cnt preset near saturation via 65535 forced events → a second request is captured in IDLE after ACK, and force_cnt stays at 0xFFFF.
